// File: rtl/timeout_counter_p.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timeout_counter_p : programmable-limit event/timeout counter (saturate/wrap)
// Optional snapshot capture port enabled by TIMEOUT_COUNTER_SNAPSHOT_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module timeout_counter_p #(
  parameter int WIDTH         = 16,
  parameter int DEFAULT_LIMIT = 5000,
  parameter int WRAPW         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             mode_wrap,
  input  logic [WIDTH-1:0] limit_in,
  input  logic [WIDTH-1:0] cmp_val,
`ifdef TIMEOUT_COUNTER_SNAPSHOT_EN
  input  logic             snap,
`endif
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             done,
  output logic             wrap,
  output logic [WRAPW-1:0] wraps,
  output logic             cmp_hit,
  output logic             running,
  output logic [WIDTH-1:0] snapshot
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES    = '1;
  // An all-ones limit is pulled down by one so limit+1 still fits in count.
  localparam logic [WIDTH-1:0] LIMIT_CLAMP = ALL_ONES - 1'b1;
  localparam logic [WIDTH-1:0] RESET_LIMIT = WIDTH'(DEFAULT_LIMIT);
  localparam logic [WRAPW-1:0] WRAPS_MAX   = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [WRAPW-1:0] wraps_q, wraps_d;
  logic             cmp_hit_q, cmp_hit_d;
  logic [WIDTH-1:0] snapshot_q, snapshot_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    mode_d     = mode_q;
    overflow_d = overflow_q;
    wraps_d    = wraps_q;
    done_d     = 1'b0;
    wrap_d     = 1'b0;
    cmp_hit_d  = (state_q == S_RUN) && (count_q == cmp_val);
`ifdef TIMEOUT_COUNTER_SNAPSHOT_EN
    snapshot_d = snap ? count_q : snapshot_q;
`else
    snapshot_d = '0;
`endif

    if (start) begin
      state_d    = S_RUN;
      count_d    = '0;
      wraps_d    = '0;
      limit_d    = (limit_in == ALL_ONES) ? LIMIT_CLAMP : limit_in;
      mode_d     = mode_wrap;
      overflow_d = 1'b0;
    end else if (stop && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      overflow_d = 1'b0;
    end else if ((state_q == S_RUN) && enable) begin
      if (count_q < limit_q) begin
        count_d = count_q + 1'b1;
      end else if (mode_q) begin
        count_d = '0;
        wrap_d  = 1'b1;
        if (wraps_q != WRAPS_MAX) begin
          wraps_d = wraps_q + 1'b1;
        end
      end else begin
        count_d    = limit_q + 1'b1;
        state_d    = S_DONE;
        done_d     = 1'b1;
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      limit_q    <= RESET_LIMIT;
      mode_q     <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      wraps_q    <= '0;
      cmp_hit_q  <= 1'b0;
      snapshot_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      mode_q     <= mode_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
      wraps_q    <= wraps_d;
      cmp_hit_q  <= cmp_hit_d;
      snapshot_q <= snapshot_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign done     = done_q;
  assign wrap     = wrap_q;
  assign wraps    = wraps_q;
  assign cmp_hit  = cmp_hit_q;
  assign running  = (state_q == S_RUN);
  assign snapshot = snapshot_q;

endmodule
`default_nettype wire

// File: tb/tb_timeout_counter_p.sv
`default_nettype none
// tb_timeout_counter_p : directed plus random stimulus against a behavioural model.
// A second 4-bit instance covers the all-ones limit clamp.
module tb_timeout_counter_p;

  localparam int W     = 16;
  localparam int WW    = 8;
  localparam int MAXV  = (1 << W) - 1;
  localparam int WMAX  = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 0, stop = 0, enable = 0, mode_wrap = 0, snap = 0;
  logic [W-1:0]  limit_in = '0, cmp_val = '0;
  logic [W-1:0]  count, snapshot;
  logic          overflow, done, wrap, cmp_hit, running;
  logic [WW-1:0] wraps;

  logic          s4_start = 0, s4_stop = 0, s4_enable = 0;
  logic [3:0]    s4_limit = '0;
  logic [3:0]    s4_count, s4_snapshot;
  logic          s4_overflow, s4_done, s4_wrap, s4_cmp_hit, s4_running;
  logic [3:0]    s4_wraps;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  int m_count = 0, m_limit = 5000, m_wraps = 0, m_snap = 0;
  bit m_run = 0, m_halt = 0, m_wmode = 0, m_done = 0, m_wrap = 0, m_cmp = 0;

  always #5 clk = ~clk;

  timeout_counter_p #(.WIDTH(W), .DEFAULT_LIMIT(5000), .WRAPW(WW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .enable(enable),
    .mode_wrap(mode_wrap), .limit_in(limit_in), .cmp_val(cmp_val),
`ifdef TIMEOUT_COUNTER_SNAPSHOT_EN
    .snap(snap),
`endif
    .count(count), .overflow(overflow), .done(done), .wrap(wrap),
    .wraps(wraps), .cmp_hit(cmp_hit), .running(running), .snapshot(snapshot)
  );

  timeout_counter_p #(.WIDTH(4), .DEFAULT_LIMIT(10), .WRAPW(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(s4_start), .stop(s4_stop), .enable(s4_enable),
    .mode_wrap(1'b0), .limit_in(s4_limit), .cmp_val(4'd0),
`ifdef TIMEOUT_COUNTER_SNAPSHOT_EN
    .snap(1'b0),
`endif
    .count(s4_count), .overflow(s4_overflow), .done(s4_done), .wrap(s4_wrap),
    .wraps(s4_wraps), .cmp_hit(s4_cmp_hit), .running(s4_running), .snapshot(s4_snapshot)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_limit = 5000; m_wraps = 0; m_snap = 0;
    m_run = 0; m_halt = 0; m_wmode = 0; m_done = 0; m_wrap = 0; m_cmp = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    m_cmp = m_run && (m_count == int'(cmp_val));
`ifdef TIMEOUT_COUNTER_SNAPSHOT_EN
    if (snap) m_snap = m_count;
`endif
    m_done = 0;
    m_wrap = 0;
    if (start) begin
      m_count = 0;
      m_wraps = 0;
      m_run   = 1;
      m_halt  = 0;
      m_limit = (int'(limit_in) > MAXV - 1) ? MAXV - 1 : int'(limit_in);
      m_wmode = mode_wrap;
    end else if (stop) begin
      m_run  = 0;
      m_halt = 0;
    end else if (m_run && enable) begin
      if (m_wmode) begin
        m_count = (m_count + 1) % (m_limit + 1);
        if (m_count == 0) begin
          m_wrap = 1;
          if (m_wraps < WMAX) m_wraps++;
        end
      end else begin
        m_count++;
        if (m_count > m_limit) begin
          m_run  = 0;
          m_halt = 1;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"},    count,    m_count);
    check({tag, ".overflow"}, overflow, m_halt);
    check({tag, ".done"},     done,     m_done);
    check({tag, ".wrap"},     wrap,     m_wrap);
    check({tag, ".wraps"},    wraps,    m_wraps);
    check({tag, ".cmp_hit"},  cmp_hit,  m_cmp);
    check({tag, ".running"},  running,  m_run);
    check({tag, ".snapshot"}, snapshot, m_snap);
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_start(input int lim, input bit wm, input string tag);
    start = 1; limit_in = W'(lim); mode_wrap = wm;
    step(tag);
    start = 0;
  endtask

  initial begin
    #1;
    compare_all("reset");
    #11 reset = 0;

    // saturate run to 5000
    enable = 1;
    do_start(5000, 0, "p1.start");
    for (int i = 0; i < 5000; i++) step("p1.run");
    check("p1.count_at_limit", count, 5000);
    step("p1.term");
    check("p1.count_term", count, 5001);
    check("p1.done_pulse", done, 1);
    for (int i = 0; i < 4; i++) step("p1.hold");
    check("p1.overflow_held", overflow, 1);
    check("p1.done_once", done, 0);

    // wrap mode, limit 3, ten enabled cycles
    do_start(3, 1, "p2.start");
    for (int i = 0; i < 9; i++) step("p2.run");
    check("p2.wraps", wraps, 2);
    check("p2.count", count, 1);

    // start and stop together at count 7: start wins
    do_start(30, 0, "p4.start");
    for (int i = 0; i < 100 && m_count != 7; i++) step("p4.run");
    check("p4.reach7", count, 7);
    start = 1; stop = 1; limit_in = 20;
    step("p4.both");
    start = 0; stop = 0;
    check("p4.count0", count, 0);
    check("p4.running", running, 1);
    for (int i = 0; i < 25; i++) step("p4.lim20");
    check("p4.done_at21", count, 21);

    // compare hit and stop at 9
    cmp_val = 5;
    do_start(30, 0, "p5.start");
    for (int i = 0; i < 100 && m_count != 9; i++) step("p5.run");
    stop = 1;
    step("p5.stop");
    stop = 0;
    for (int i = 0; i < 3; i++) step("p5.idle");
    check("p5.count_held", count, 9);
    check("p5.running", running, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 49) == 0);
      stop      = ($urandom_range(0, 79) == 0);
      enable    = ($urandom_range(0, 3) != 0);
      mode_wrap = $urandom_range(0, 1);
      limit_in  = ($urandom_range(0, 15) == 0) ? W'(MAXV) : W'($urandom_range(0, 40));
      cmp_val   = W'($urandom_range(0, 40));
      snap      = ($urandom_range(0, 9) == 0);
      step("rnd");
    end
    start = 0; stop = 0; snap = 0;

    // async reset between edges
    enable = 1;
    do_start(100, 0, "p6.start");
    for (int i = 0; i < 12; i++) step("p6.run");
    #2 reset = 1;
    #1;
    model_reset();
    compare_all("p6.async");
    #1 reset = 0;
    step("p6.after");

`ifdef TIMEOUT_COUNTER_SNAPSHOT_EN
    do_start(200, 0, "p7.start");
    for (int i = 0; i < 100 && m_count != 42; i++) step("p7.run");
    snap = 1;
    step("p7.snap");
    snap = 0;
    for (int i = 0; i < 5; i++) step("p7.hold");
    check("p7.snapshot42", snapshot, 42);
`endif

    // 4-bit instance: all-ones limit clamps to 14, run ends at 15
    s4_start = 1; s4_limit = 4'hF; s4_enable = 1;
    @(posedge clk); #1;
    s4_start = 0;
    check("w4.count0", s4_count, 0);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      check("w4.count",    s4_count,    (k < 15) ? k : 15);
      check("w4.done",     s4_done,     (k == 15));
      check("w4.overflow", s4_overflow, (k >= 15));
      check("w4.running",  s4_running,  (k < 15));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
